// File: rtl/seg7_pkg.sv
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared types and segment geometry for the 7-seg streamer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
  } seg_fields_t;

  typedef union packed {
    logic [6:0]  raw;
    seg_fields_t individual;
  } Segments;

  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_id_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Glyph-local pixel (x,y) inside segment `id` for a w x h glyph of thickness t.
  function automatic logic seg_lit(input seg_id_t id, input int x, input int y,
                                   input int w, input int h, input int t);
    logic span_x;
    logic left;
    logic right;
    logic upper;
    logic hit;
    span_x = (x >= t) && (x < w - t);
    left   = (x < t);
    right  = (x >= w - t) && (x < w);
    upper  = (y < h / 2);
    case (id)
      SEG_A:   hit = span_x && (y < t);
      SEG_D:   hit = span_x && (y >= h - t) && (y < h);
      SEG_G:   hit = span_x && (y >= h / 2 - t / 2) && (y < h / 2 + t / 2);
      SEG_F:   hit = left && upper;
      SEG_E:   hit = left && !upper && (y < h);
      SEG_B:   hit = right && upper;
      SEG_C:   hit = right && !upper && (y < h);
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_glyph_column.sv
// ============================================================================
//  Module      : seg7_glyph_column
//  Description : Combinational 8-row column slice of one glyph plus its gap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_glyph_column
  import seg7_pkg::*;
#(
  parameter int GLYPH_W     = 21,
  parameter int GAP_W       = 3,
  parameter int GLYPH_PAGES = 4,
  parameter int SEG_T       = 4
) (
  input  Segments                                seg,
  input  logic                                   dp,
  input  logic [$clog2(GLYPH_W+GAP_W)-1:0]       x,
  input  logic [$clog2(GLYPH_PAGES)-1:0]         page,
  output logic [7:0]                             pixels
);

  localparam int H    = 8 * GLYPH_PAGES;
  localparam int DP_W = (SEG_T < GAP_W) ? SEG_T : GAP_W;

  always_comb begin
    int xi;
    int yi;
    pixels = '0;
    xi     = int'(x);
    yi     = 0;
    for (int k = 0; k < 8; k++) begin
      yi = 8 * int'(page) + k;
      if (xi < GLYPH_W) begin
        pixels[k] = (seg.individual.a & seg_lit(SEG_A, xi, yi, GLYPH_W, H, SEG_T))
                  | (seg.individual.b & seg_lit(SEG_B, xi, yi, GLYPH_W, H, SEG_T))
                  | (seg.individual.c & seg_lit(SEG_C, xi, yi, GLYPH_W, H, SEG_T))
                  | (seg.individual.d & seg_lit(SEG_D, xi, yi, GLYPH_W, H, SEG_T))
                  | (seg.individual.e & seg_lit(SEG_E, xi, yi, GLYPH_W, H, SEG_T))
                  | (seg.individual.f & seg_lit(SEG_F, xi, yi, GLYPH_W, H, SEG_T))
                  | (seg.individual.g & seg_lit(SEG_G, xi, yi, GLYPH_W, H, SEG_T));
      end else begin
        // Decimal point sits in the first gap columns, bottom-aligned with segment d.
        pixels[k] = dp & (xi - GLYPH_W < DP_W) & (yi >= H - SEG_T);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg7_digit_streamer.sv
// ============================================================================
//  Module      : seg7_digit_streamer
//  Description : Streams SSD1306 page-ordered column bytes for a digit row.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_digit_streamer
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 6,
  parameter int GLYPH_W     = 21,
  parameter int GAP_W       = 3,
  parameter int GLYPH_PAGES = 4,
  parameter int SEG_T       = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  Segments [DIGITS-1:0]                          segments_in,
  input  logic [DIGITS-1:0]                             dp_in,
  input  logic                                          invert_in,
  output logic                                          busy,
  output logic                                          valid,
  input  logic                                          ready,
  output logic [7:0]                                    pixels,
  output logic [$clog2(GLYPH_PAGES)-1:0]                page_idx,
  output logic [$clog2(DIGITS*(GLYPH_W+GAP_W))-1:0]     col_idx,
  output logic                                          last
);

  localparam int STRIDE = GLYPH_W + GAP_W;
  localparam int COLS   = DIGITS * STRIDE;
  localparam int PAGE_W = $clog2(GLYPH_PAGES);
  localparam int COL_W  = $clog2(COLS);
  localparam int X_W    = $clog2(STRIDE);
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if ((DIGITS < 1) || (GAP_W < 1) || (GLYPH_PAGES < 2) || (SEG_T < 1) ||
      (2 * SEG_T >= GLYPH_W) || ((SEG_T % 2) != 0)) begin : g_param_check
    $error("seg7_digit_streamer: illegal geometry parameters");
  end

  state_t               r_state;
  state_t               w_state_nxt;
  Segments [DIGITS-1:0] r_seg;
  logic [DIGITS-1:0]    r_dp;
  logic                 r_invert;
  logic [PAGE_W-1:0]    r_page;
  logic [PAGE_W-1:0]    w_page_nxt;
  logic [COL_W-1:0]     r_col;
  logic [COL_W-1:0]     w_col_nxt;
  logic [DIG_W-1:0]     r_dig;
  logic [DIG_W-1:0]     w_dig_nxt;
  logic [X_W-1:0]       r_x;
  logic [X_W-1:0]       w_x_nxt;
  logic [7:0]           r_pixels;
  logic                 r_last;
  logic                 w_load;
  logic                 w_last_nxt;
  logic                 w_accept;
  Segments              w_glyph_seg;
  logic                 w_glyph_dp;
  logic                 w_glyph_inv;
  logic [7:0]           w_glyph_px;

  assign w_accept = (r_state == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Counters describe the byte being presented; w_*_nxt is the byte loaded next.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_page_nxt  = r_page;
    w_col_nxt   = r_col;
    w_dig_nxt   = r_dig;
    w_x_nxt     = r_x;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_STREAM;
          w_load      = 1'b1;
          w_page_nxt  = '0;
          w_col_nxt   = '0;
          w_dig_nxt   = '0;
          w_x_nxt     = '0;
        end
      end
      ST_STREAM: begin
        // valid is constantly high while streaming, so ready alone completes a handshake.
        if (ready) begin
          if (r_last) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_load = 1'b1;
            if (r_col == COL_W'(COLS - 1)) begin
              w_col_nxt  = '0;
              w_dig_nxt  = '0;
              w_x_nxt    = '0;
              w_page_nxt = r_page + PAGE_W'(1);
            end else begin
              w_col_nxt = r_col + COL_W'(1);
              if (r_x == X_W'(STRIDE - 1)) begin
                w_x_nxt   = '0;
                w_dig_nxt = r_dig + DIG_W'(1);
              end else begin
                w_x_nxt = r_x + X_W'(1);
              end
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_last_nxt = (w_page_nxt == PAGE_W'(GLYPH_PAGES - 1)) && (w_col_nxt == COL_W'(COLS - 1));

    // The first byte renders straight from the inputs being snapshotted this cycle.
    if (r_state == ST_IDLE) begin
      w_glyph_seg = segments_in[0];
      w_glyph_dp  = dp_in[0];
      w_glyph_inv = invert_in;
    end else begin
      w_glyph_seg = r_seg[w_dig_nxt];
      w_glyph_dp  = r_dp[w_dig_nxt];
      w_glyph_inv = r_invert;
    end
  end

  seg7_glyph_column #(
    .GLYPH_W     (GLYPH_W),
    .GAP_W       (GAP_W),
    .GLYPH_PAGES (GLYPH_PAGES),
    .SEG_T       (SEG_T)
  ) u_glyph (
    .seg    (w_glyph_seg),
    .dp     (w_glyph_dp),
    .x      (w_x_nxt),
    .page   (w_page_nxt),
    .pixels (w_glyph_px)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg    <= '0;
      r_dp     <= '0;
      r_invert <= 1'b0;
      r_page   <= '0;
      r_col    <= '0;
      r_dig    <= '0;
      r_x      <= '0;
      r_pixels <= '0;
      r_last   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_seg    <= segments_in;
        r_dp     <= dp_in;
        r_invert <= invert_in;
      end
      if (w_load) begin
        r_page   <= w_page_nxt;
        r_col    <= w_col_nxt;
        r_dig    <= w_dig_nxt;
        r_x      <= w_x_nxt;
        r_pixels <= w_glyph_px ^ {8{w_glyph_inv}};
        r_last   <= w_last_nxt;
      end
    end
  end

  assign busy     = (r_state == ST_STREAM);
  assign valid    = (r_state == ST_STREAM);
  assign pixels   = r_pixels;
  assign page_idx = r_page;
  assign col_idx  = r_col;
  assign last     = r_last;

endmodule

`default_nettype wire

// File: tb/tb_seg7_digit_streamer.sv
// ============================================================================
//  Module      : tb_seg7_digit_streamer
//  Description : Randomised self-checking bench against a pixel-geometry model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_digit_streamer;
  import seg7_pkg::*;

  localparam int D = 6, W = 21, GAP = 3, P = 4, T = 4;
  localparam int C = D * (W + GAP);
  localparam int FRAME = P * C;
  localparam int SD = 2, SW = 11, SGAP = 3, SP = 2, ST = 2;
  localparam int SC = SD * (SW + SGAP);
  localparam int SFRAME = SP * SC;

  logic clk = 1'b0;
  logic reset, start, invert_in, ready;
  Segments [D-1:0] segments_in;
  logic [D-1:0] dp_in;
  logic busy, valid, last;
  logic [7:0] pixels;
  logic [1:0] page_idx;
  logic [7:0] col_idx;

  logic s_start, s_invert, s_ready;
  Segments [SD-1:0] s_segments;
  logic [SD-1:0] s_dp;
  logic s_busy, s_valid, s_last;
  logic [7:0] s_pixels;
  logic [0:0] s_page;
  logic [4:0] s_col;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] m_seg [8];
  logic       m_dp  [8];
  logic       m_inv;
  logic [7:0] got   [FRAME];

  always #5 clk = ~clk;

  seg7_digit_streamer #(.DIGITS(D), .GLYPH_W(W), .GAP_W(GAP), .GLYPH_PAGES(P), .SEG_T(T)) dut (
    .clk(clk), .reset(reset), .start(start), .segments_in(segments_in), .dp_in(dp_in),
    .invert_in(invert_in), .busy(busy), .valid(valid), .ready(ready), .pixels(pixels),
    .page_idx(page_idx), .col_idx(col_idx), .last(last));

  seg7_digit_streamer #(.DIGITS(SD), .GLYPH_W(SW), .GAP_W(SGAP), .GLYPH_PAGES(SP), .SEG_T(ST)) dut_small (
    .clk(clk), .reset(reset), .start(s_start), .segments_in(s_segments), .dp_in(s_dp),
    .invert_in(s_invert), .busy(s_busy), .valid(s_valid), .ready(s_ready), .pixels(s_pixels),
    .page_idx(s_page), .col_idx(s_col), .last(s_last));

  // bit0=a .. bit6=g
  function automatic Segments mk_seg(input logic [6:0] b);
    Segments s;
    s.individual.a = b[0];
    s.individual.b = b[1];
    s.individual.c = b[2];
    s.individual.d = b[3];
    s.individual.e = b[4];
    s.individual.f = b[5];
    s.individual.g = b[6];
    return s;
  endfunction

  function automatic logic [7:0] model_byte(input int w, input int gap, input int t,
                                            input int pages, input int page, input int col);
    logic [7:0] b;
    logic [6:0] sg;
    int h, s, d, x, y, dpw;
    h = 8 * pages;
    s = w + gap;
    d = col / s;
    x = col % s;
    sg = m_seg[d];
    dpw = (t < gap) ? t : gap;
    for (int k = 0; k < 8; k++) begin
      y = 8 * page + k;
      if (x < w)
        b[k] = (sg[0] && x >= t && x < w - t && y < t)
            || (sg[3] && x >= t && x < w - t && y >= h - t)
            || (sg[6] && x >= t && x < w - t && y >= h / 2 - t / 2 && y < h / 2 + t / 2)
            || (sg[5] && x < t && y < h / 2)
            || (sg[4] && x < t && y >= h / 2)
            || (sg[1] && x >= w - t && y < h / 2)
            || (sg[2] && x >= w - t && y >= h / 2);
      else
        b[k] = m_dp[d] && (x - w) < dpw && y >= h - t;
    end
    return m_inv ? ~b : b;
  endfunction

  task automatic apply(input logic [41:0] segbits, input logic [5:0] dp, input logic inv);
    for (int d = 0; d < D; d++) begin
      segments_in[d] = mk_seg(segbits[7*d +: 7]);
      m_seg[d] = segbits[7*d +: 7];
      m_dp[d] = dp[d];
    end
    dp_in = dp;
    invert_in = inv;
    m_inv = inv;
  endtask

  task automatic apply_random;
    logic [63:0] r;
    r = {$urandom, $urandom};
    apply(r[41:0], r[47:42], 1'b0);
  endtask

  task automatic stream_frame(input int stall_at, input int stall_len, input bit rand_ready,
                              input bit disturb, input int abort_at);
    int idx, stalled;
    bit hs, done;
    logic [7:0] exp;
    logic [63:0] r;
    idx = 0; stalled = 0; done = 0;
    ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      if (abort_at >= 0 && idx == abort_at) break;
      exp = model_byte(W, GAP, T, P, idx / C, idx % C);
      got[idx] = pixels;
      vectors++;
      if (valid !== 1'b1 || busy !== 1'b1 || pixels !== exp || int'(page_idx) != idx / C ||
          int'(col_idx) != idx % C || last !== (idx == FRAME - 1)) begin
        miscompares++;
        $display("FAIL byte%0d: valid=%b busy=%b pixels=%h page=%0d col=%0d last=%b; want pixels=%h page=%0d col=%0d last=%b",
                 idx, valid, busy, pixels, page_idx, col_idx, last, exp, idx / C, idx % C, idx == FRAME - 1);
      end
      if (stall_len > 0 && idx == stall_at && stalled < stall_len) begin
        ready = 1'b0;
        stalled++;
      end else if (rand_ready) begin
        ready = ($urandom_range(0, 3) != 0);
      end else begin
        ready = 1'b1;
      end
      if (disturb) begin
        start = (idx == FRAME - 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
        r = {$urandom, $urandom};
        for (int d = 0; d < D; d++) segments_in[d] = mk_seg(r[7*d +: 7]);
        dp_in = r[47:42];
        invert_in = r[48];
      end
      hs = ready && valid;
      @(posedge clk); #1;
      if (hs) begin
        if (idx == FRAME - 1) done = 1;
        idx++;
      end
    end
    start = 1'b0;
    ready = 1'b1;
    if (abort_at < 0) begin
      vectors++;
      if (!done || valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL frame_end: done=%0d valid=%b busy=%b; want done=1 valid=0 busy=0", done, valid, busy);
      end
      vectors++;
      if (idx != FRAME) begin
        miscompares++;
        $display("FAIL byte_count: got %0d want %0d", idx, FRAME);
      end
    end
  endtask

  task automatic test_reset;
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0 || last !== 1'b0 || pixels !== 8'h00 ||
        page_idx !== 2'd0 || col_idx !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b valid=%b last=%b pixels=%h page=%0d col=%0d; want all zero",
               busy, valid, last, pixels, page_idx, col_idx);
    end
    vectors++;
    if (s_busy !== 1'b0 || s_valid !== 1'b0 || s_pixels !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_small: busy=%b valid=%b pixels=%h; want 0 0 00", s_busy, s_valid, s_pixels);
    end
  endtask

  task automatic check_got(input string name, input int i, input logic [7:0] want);
    vectors++;
    if (got[i] !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got[i], want);
    end
  endtask

  task automatic test_eight_dp;
    apply(42'h7F, 6'b000001, 1'b0);
    stream_frame(-1, 0, 0, 0, -1);
    check_got("p0c0", 0, 8'hFF);
    check_got("p0c10", 10, 8'h0F);
    check_got("p1c10", C + 10, 8'hC0);
    check_got("p2c10", 2 * C + 10, 8'h03);
    check_got("p3c10", 3 * C + 10, 8'hF0);
    check_got("p3c21", 3 * C + 21, 8'hF0);
    check_got("p3c24", 3 * C + 24, 8'h00);
  endtask

  task automatic test_stall;
    apply_random();
    stream_frame(100, 5, 0, 0, -1);
  endtask

  task automatic test_invert_blank;
    int bad;
    apply(42'h0, 6'h0, 1'b1);
    stream_frame(-1, 0, 0, 0, -1);
    bad = 0;
    for (int i = 0; i < FRAME; i++) if (got[i] !== 8'hFF) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL invert_blank: %0d bytes differ from FF, want 0", bad);
    end
  endtask

  task automatic test_back_to_back;
    apply_random();
    stream_frame(-1, 0, 1, 1, -1);
    for (int n = 0; n < 2; n++) begin
      apply_random();
      m_inv = $urandom_range(0, 1);
      invert_in = m_inv;
      stream_frame(-1, 0, 1, 0, -1);
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] exp;
    apply_random();
    stream_frame(-1, 0, 0, 0, 300);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0 || last !== 1'b0 || pixels !== 8'h00 ||
        page_idx !== 2'd0 || col_idx !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%b busy=%b last=%b pixels=%h page=%0d col=%0d; want all zero",
               valid, busy, last, pixels, page_idx, col_idx);
    end
    apply_random();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp = model_byte(W, GAP, T, P, 0, 0);
    vectors++;
    if (valid !== 1'b1 || busy !== 1'b1 || pixels !== exp || page_idx !== 2'd0 || col_idx !== 8'd0) begin
      miscompares++;
      $display("FAIL restart_first: valid=%b busy=%b pixels=%h page=%0d col=%0d; want 1 1 %h 0 0",
               valid, busy, pixels, page_idx, col_idx, exp);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_small_digit_one;
    int idx;
    bit done, hs;
    logic [7:0] exp;
    logic [7:0] sgot [SFRAME];
    logic [31:0] r;
    r = $urandom;
    s_segments[0] = mk_seg(7'b0000110);
    m_seg[0] = 7'b0000110;
    m_dp[0] = 1'b0;
    s_segments[1] = mk_seg(r[6:0]);
    m_seg[1] = r[6:0];
    m_dp[1] = r[7];
    s_dp = {r[7], 1'b0};
    s_invert = 1'b0;
    m_inv = 1'b0;
    s_ready = 1'b1;
    idx = 0; done = 0;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      exp = model_byte(SW, SGAP, ST, SP, idx / SC, idx % SC);
      sgot[idx] = s_pixels;
      vectors++;
      if (s_valid !== 1'b1 || s_pixels !== exp || int'(s_page) != idx / SC ||
          int'(s_col) != idx % SC || s_last !== (idx == SFRAME - 1)) begin
        miscompares++;
        $display("FAIL small_byte%0d: valid=%b pixels=%h page=%0d col=%0d last=%b; want pixels=%h page=%0d col=%0d",
                 idx, s_valid, s_pixels, s_page, s_col, s_last, exp, idx / SC, idx % SC);
      end
      hs = s_valid && s_ready;
      @(posedge clk); #1;
      if (hs) begin
        if (idx == SFRAME - 1) done = 1;
        idx++;
      end
    end
    vectors++;
    if (!done || idx != SFRAME || s_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL small_count: bytes=%0d busy=%b; want %0d 0", idx, s_busy, SFRAME);
    end
    vectors++;
    if (sgot[9] !== 8'hFF || sgot[0] !== 8'h00 || sgot[SC + 9] !== 8'hFF) begin
      miscompares++;
      $display("FAIL small_glyph: p0c9=%h p0c0=%h p1c9=%h; want FF 00 FF", sgot[9], sgot[0], sgot[SC + 9]);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ready = 1'b1; invert_in = 1'b0;
    segments_in = '0; dp_in = '0;
    s_start = 1'b0; s_ready = 1'b1; s_invert = 1'b0; s_segments = '0; s_dp = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_eight_dp();
    test_stall();
    test_invert_blank();
    test_back_to_back();
    test_reset_midframe();
    test_small_digit_one();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
